// File: rtl/upload_pkg.sv
// Shared types and defaults for the HPS upload server: FSM state encoding,
// default fill byte and the address range helper.
package upload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } upload_state_t;

  localparam logic [7:0] FILL_DEFAULT = 8'hFF;
  localparam int         HPS_ADDR_W   = 25;

  // The whole HPS address takes part in the test, so aliases above ADDR_W
  // are reported as out of range instead of wrapping onto real memory.
  function automatic logic addr_in_range(input logic [HPS_ADDR_W-1:0] addr,
                                         input logic [HPS_ADDR_W-1:0] size);
    return (addr < size);
  endfunction

endpackage

// File: rtl/upload_server.sv
// Serves HPS upload read strobes from a request/acknowledge core memory port,
// stalling the HPS while a fetch is outstanding and keeping a running checksum.
module upload_server
  import upload_pkg::*;
#(
  parameter int         ADDR_W   = 14,
  parameter int         SIZE     = 16384,
  parameter logic [7:0] UP_INDEX = 8'd2,
  parameter logic [7:0] FILL     = FILL_DEFAULT
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic [7:0]        checksum,
  output logic              done
);

  localparam logic [HPS_ADDR_W-1:0] SIZE_L = HPS_ADDR_W'(SIZE);

  upload_state_t     state_r, state_s;
  logic              sel_s, sel_d_r;
  logic              mem_req_r, mem_req_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic              wait_r, wait_s;
  logic [7:0]        din_r, din_s;
  logic [7:0]        checksum_r, checksum_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;

  assign sel_s = ioctl_upload && (ioctl_index == UP_INDEX);

  // Session select history for rising-edge detection; cleared by reset so an
  // upload already running at reset release opens a new session.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sel_d_r <= 1'b0;
    end else begin
      sel_d_r <= sel_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      mem_req_r  <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      wait_r     <= 1'b0;
      din_r      <= 8'h00;
      checksum_r <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      mem_req_r  <= mem_req_s;
      mem_addr_r <= mem_addr_s;
      wait_r     <= wait_s;
      din_r      <= din_s;
      checksum_r <= checksum_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  // Session tracking, next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    mem_req_s  = mem_req_r;
    mem_addr_s = mem_addr_r;
    wait_s     = wait_r;
    din_s      = din_r;
    checksum_s = checksum_r;
    busy_s     = busy_r;
    done_s     = 1'b0;

    if (sel_s && !sel_d_r) begin
      busy_s     = 1'b1;
      checksum_s = 8'h00;
    end else if (busy_r && !ioctl_upload) begin
      busy_s = 1'b0;
      done_s = 1'b1;
    end else begin
      busy_s = busy_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (ioctl_rd && busy_r) begin
          if (addr_in_range(ioctl_addr, SIZE_L)) begin
            mem_addr_s = ioctl_addr[ADDR_W-1:0];
            mem_req_s  = 1'b1;
            wait_s     = 1'b1;
            state_s    = ST_REQ;
          end else begin
            din_s      = FILL;
            checksum_s = checksum_s + FILL;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          din_s      = mem_data;
          checksum_s = checksum_s + mem_data;
          mem_req_s  = 1'b0;
          wait_s     = 1'b0;
          state_s    = ST_IDLE;
        end else if (!ioctl_upload) begin
          // Session aborted: finish the bus handshake but discard the byte.
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (mem_ack) begin
          mem_req_s = 1'b0;
          wait_s    = 1'b0;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        mem_req_s = 1'b0;
        wait_s    = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  assign ioctl_din  = din_r;
  assign ioctl_wait = wait_r;
  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;
  assign busy       = busy_r;
  assign checksum   = checksum_r;
  assign done       = done_r;

endmodule
